// File: rtl/itlb_refill_if.sv
// Bundle of the refill walker's request, memory-read and TLB-write signals.
interface itlb_refill_if #(
    parameter int unsigned CONFIG_AW          = 32,
    parameter int unsigned CONFIG_DW          = 32,
    parameter int unsigned CONFIG_P_PAGE_SIZE = 13,
    parameter int unsigned CONFIG_ITLB_P_SETS = 7
);
    localparam int unsigned VPN_DW = CONFIG_AW - CONFIG_P_PAGE_SIZE;

    logic                          start;
    logic [VPN_DW-1:0]             vpn;
    logic [CONFIG_AW-1:0]          ptbr;
    logic                          abort;
    logic                          busy;
    logic                          done;
    logic                          fault;
    logic                          mem_req;
    logic [CONFIG_AW-1:0]          mem_addr;
    logic                          mem_ready;
    logic                          mem_rvalid;
    logic [CONFIG_DW-1:0]          mem_rdata;
    logic                          msr_imm_tlbl_we;
    logic [CONFIG_ITLB_P_SETS-1:0] msr_imm_tlbl_idx;
    logic [CONFIG_DW-1:0]          msr_imm_tlbl_nxt;
    logic                          msr_imm_tlbh_we;
    logic [CONFIG_ITLB_P_SETS-1:0] msr_imm_tlbh_idx;
    logic [CONFIG_DW-1:0]          msr_imm_tlbh_nxt;

    // Walker side
    modport master (
        input  start, vpn, ptbr, abort, mem_ready, mem_rvalid, mem_rdata,
        output busy, done, fault, mem_req, mem_addr,
               msr_imm_tlbl_we, msr_imm_tlbl_idx, msr_imm_tlbl_nxt,
               msr_imm_tlbh_we, msr_imm_tlbh_idx, msr_imm_tlbh_nxt
    );

    // Requester / memory / TLB side
    modport slave (
        output start, vpn, ptbr, abort, mem_ready, mem_rvalid, mem_rdata,
        input  busy, done, fault, mem_req, mem_addr,
               msr_imm_tlbl_we, msr_imm_tlbl_idx, msr_imm_tlbl_nxt,
               msr_imm_tlbh_we, msr_imm_tlbh_idx, msr_imm_tlbh_nxt
    );
endinterface

// File: rtl/itlb_refill.sv
// Two-level hardware page-table walker that refills one ITLB entry on a miss.
module itlb_refill #(
    parameter int unsigned CONFIG_AW          = 32,
    parameter int unsigned CONFIG_DW          = 32,
    parameter int unsigned CONFIG_P_PAGE_SIZE = 13,
    parameter int unsigned CONFIG_ITLB_P_SETS = 7
) (
    input  logic             clk,
    input  logic             rst,
    itlb_refill_if.master    bus
);
    localparam int unsigned VPN_DW    = CONFIG_AW - CONFIG_P_PAGE_SIZE;
    localparam int unsigned L2_IDX_W  = 10;
    localparam int unsigned PTBR_HI_W = CONFIG_AW - 11;
    localparam int unsigned PDE_HI_W  = CONFIG_DW - 12;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_REQ, S_L1_WAIT, S_L2_REQ, S_L2_WAIT, S_FILL, S_FAULT, S_DRAIN
    } state_t;

    state_t                        state_q, state_d;
    logic [VPN_DW-1:0]             vpn_q, vpn_d;
    logic [PTBR_HI_W-1:0]          ptbr_q, ptbr_d;
    logic [PDE_HI_W-1:0]           pde_q, pde_d;
    logic [CONFIG_DW-1:0]          pte_q, pte_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          fault_q, fault_d;
    logic                          mem_req_q, mem_req_d;
    logic [CONFIG_AW-1:0]          mem_addr_q, mem_addr_d;
    logic                          we_q, we_d;
    logic [CONFIG_ITLB_P_SETS-1:0] idx_q, idx_d;
    logic [CONFIG_DW-1:0]          tlbl_nxt_q, tlbl_nxt_d;
    logic [CONFIG_DW-1:0]          tlbh_nxt_q, tlbh_nxt_d;
    logic                          mem_accept_c;
    logic                          unused_ptbr_lo;

    assign mem_accept_c   = mem_req_q & bus.mem_ready;
    assign unused_ptbr_lo = ^bus.ptbr[10:0];

    // Walk sequencing plus registered outputs derived from the next state
    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        ptbr_d  = ptbr_q;
        pde_d   = pde_q;
        pte_d   = pte_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    vpn_d   = bus.vpn;
                    ptbr_d  = bus.ptbr[CONFIG_AW-1:11];
                    state_d = S_L1_REQ;
                end
            end
            S_L1_REQ, S_L2_REQ: begin
                // An accepted request still owes a response, so an abort must drain it
                if (bus.abort)        state_d = mem_accept_c ? S_DRAIN : S_IDLE;
                else if (mem_accept_c) state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L2_WAIT;
            end
            S_L1_WAIT: begin
                if (bus.abort) begin
                    state_d = bus.mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (bus.mem_rvalid) begin
                    if (bus.mem_rdata[0]) begin
                        pde_d   = bus.mem_rdata[CONFIG_DW-1:12];
                        state_d = S_L2_REQ;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_L2_WAIT: begin
                if (bus.abort) begin
                    state_d = bus.mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (bus.mem_rvalid) begin
                    if (bus.mem_rdata[0]) begin
                        pte_d   = bus.mem_rdata;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_FILL, S_FAULT: state_d = S_IDLE;
            S_DRAIN: begin
                if (bus.mem_rvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FILL) || (state_d == S_FAULT);
        fault_d    = (state_d == S_FAULT);
        we_d       = (state_d == S_FILL);
        mem_req_d  = (state_d == S_L1_REQ) || (state_d == S_L2_REQ);
        mem_addr_d = (state_d == S_L2_REQ)
                   ? {pde_d, vpn_d[L2_IDX_W-1:0], 2'b00}
                   : {ptbr_d, vpn_d[VPN_DW-1:L2_IDX_W], 2'b00};
        idx_d      = vpn_d[CONFIG_ITLB_P_SETS-1:0];
        tlbl_nxt_d = {vpn_d, 12'b0, 1'b1};
        tlbh_nxt_d = pte_d;
    end

    // State, captured walk context and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vpn_q      <= '0;
            ptbr_q     <= '0;
            pde_q      <= '0;
            pte_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            tlbl_nxt_q <= '0;
            tlbh_nxt_q <= '0;
        end else begin
            state_q    <= state_d;
            vpn_q      <= vpn_d;
            ptbr_q     <= ptbr_d;
            pde_q      <= pde_d;
            pte_q      <= pte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            tlbl_nxt_q <= tlbl_nxt_d;
            tlbh_nxt_q <= tlbh_nxt_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.fault            = fault_q;
    assign bus.mem_req          = mem_req_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.msr_imm_tlbl_we  = we_q;
    assign bus.msr_imm_tlbl_idx = idx_q;
    assign bus.msr_imm_tlbl_nxt = tlbl_nxt_q;
    assign bus.msr_imm_tlbh_we  = we_q;
    assign bus.msr_imm_tlbh_idx = idx_q;
    assign bus.msr_imm_tlbh_nxt = tlbh_nxt_q;
endmodule

// File: tb/tb_itlb_refill.sv
// Self-checking bench for itlb_refill: vector table, random walks vs. model, abort/reset sequences.
module tb_itlb_refill;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ev_done = 0;
    int   ev_we = 0;

    itlb_refill_if bus ();

    itlb_refill dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sticky event counters used by the abort/reset sequences
    always @(negedge clk) begin
        if (bus.done === 1'b1) ev_done++;
        if ((bus.msr_imm_tlbl_we | bus.msr_imm_tlbh_we) === 1'b1) ev_we++;
    end

    typedef struct {
        logic [31:0] ptbr;
        logic [18:0] vpn;
        logic [31:0] pde;
        logic [31:0] pte;
        int          bp1, bp2, lat1, lat2;
        logic [31:0] addr1, addr2;
        int          nreq;
        logic        fault;
        int          lat;
        logic [6:0]  idx;
        logic [31:0] tlbl, tlbh;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] ptbr, input logic [18:0] vpn,
                                input logic [31:0] pde, input logic [31:0] pte,
                                input int bp1, input int bp2, input int lat1, input int lat2,
                                input logic [31:0] a1, input logic [31:0] a2, input int nreq,
                                input logic flt, input int lat, input logic [6:0] idx,
                                input logic [31:0] tl, input logic [31:0] th);
        vec_t v;
        v.ptbr = ptbr; v.vpn = vpn; v.pde = pde; v.pte = pte;
        v.bp1 = bp1; v.bp2 = bp2; v.lat1 = lat1; v.lat2 = lat2;
        v.addr1 = a1; v.addr2 = a2; v.nreq = nreq; v.fault = flt; v.lat = lat;
        v.idx = idx; v.tlbl = tl; v.tlbh = th;
        return v;
    endfunction

    // Reference: expected walk outcome from the page-table rules
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] vpn32 = {13'b0, v.vpn};
        bit l1_ok = v.pde[0];
        bit l2_ok = v.pte[0];
        r.addr1 = (v.ptbr & 32'hFFFF_F800) + (vpn32 / 1024) * 4;
        r.addr2 = (v.pde & 32'hFFFF_F000) + (vpn32 % 1024) * 4;
        r.nreq  = l1_ok ? 2 : 1;
        r.fault = !(l1_ok && l2_ok);
        r.lat   = l1_ok ? 5 + v.bp1 + v.bp2 + (v.lat1 - 1) + (v.lat2 - 1)
                        : 3 + v.bp1 + (v.lat1 - 1);
        r.idx   = 7'(vpn32 % 128);
        r.tlbl  = (vpn32 << 13) | 32'd1;
        r.tlbh  = v.pte;
        return r;
    endfunction

    // Drive one walk with a reactive memory and check every observable outcome
    task automatic run_walk(input vec_t v, input string tag);
        int t0, nreq, stall, rv_at, done_cnt, done_cyc, we_cnt, bad_we;
        bit in_req, fin, stable;
        logic flt, busy_after;
        logic [6:0] il;
        logic [31:0] a1, a2, cur, nl, nh;
        nreq = 0; stall = 0; rv_at = -1; done_cnt = 0; done_cyc = -1; we_cnt = 0; bad_we = 0;
        in_req = 0; fin = 0; stable = 1; flt = 1'bx; busy_after = 1'b1;
        il = 'x; a1 = 'x; a2 = 'x; cur = 'x; nl = 'x; nh = 'x;
        @(negedge clk);
        clr();
        bus.start = 1'b1; bus.vpn = v.vpn; bus.ptbr = v.ptbr;
        t0 = cyc;
        for (int k = 0; k < 64 && !fin; k++) begin
            @(negedge clk);
            clr();
            bus.mem_rdata = $urandom;
            if (done_cnt > 0) begin
                busy_after = bus.busy;
                fin = 1;
            end
            if (bus.done) begin
                done_cnt++; done_cyc = cyc; flt = bus.fault;
                il = bus.msr_imm_tlbl_idx; nl = bus.msr_imm_tlbl_nxt; nh = bus.msr_imm_tlbh_nxt;
                if (bus.msr_imm_tlbh_idx !== bus.msr_imm_tlbl_idx) bad_we++;
            end
            if (bus.msr_imm_tlbl_we) we_cnt++;
            if (bus.msr_imm_tlbl_we !== bus.msr_imm_tlbh_we) bad_we++;
            if (bus.msr_imm_tlbl_we && !bus.done) bad_we++;
            if (bus.mem_req) begin
                if (!in_req) begin
                    in_req = 1; nreq++; stall = 0; cur = bus.mem_addr;
                    if (nreq == 1) a1 = bus.mem_addr; else a2 = bus.mem_addr;
                end else if (bus.mem_addr !== cur) begin
                    stable = 0;
                end
                if (stall >= ((nreq == 1) ? v.bp1 : v.bp2)) begin
                    bus.mem_ready = 1'b1;
                    in_req = 0;
                    rv_at = cyc + ((nreq == 1) ? v.lat1 : v.lat2);
                end else begin
                    stall++;
                end
            end
            if (cyc == rv_at) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = (nreq == 1) ? v.pde : v.pte;
            end
        end
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, " latency"}, 32'(done_cyc - t0), 32'(v.lat));
        chk({tag, " fault"}, {31'b0, flt}, {31'b0, v.fault});
        chk({tag, " requests"}, 32'(nreq), 32'(v.nreq));
        chk({tag, " l1_addr"}, a1, v.addr1);
        if (v.nreq == 2) chk({tag, " l2_addr"}, a2, v.addr2);
        chk({tag, " addr_stable"}, {31'b0, stable}, 32'd1);
        chk({tag, " we_consistency"}, 32'(bad_we), 32'd0);
        chk({tag, " we_count"}, 32'(we_cnt), v.fault ? 32'd0 : 32'd1);
        if (!v.fault) begin
            chk({tag, " idx"}, {25'b0, il}, {25'b0, v.idx});
            chk({tag, " tlbl_nxt"}, nl, v.tlbl);
            chk({tag, " tlbh_nxt"}, nh, v.tlbh);
        end
        chk({tag, " busy_after"}, {31'b0, busy_after}, 32'd0);
    endtask

    vec_t tbl[5];

    initial begin
        int d0, w0;
        vec_t r;

        tbl[0] = mk(32'h0000_1000, 19'h12345, 32'h0040_0001, 32'hABCD_E019, 0, 0, 1, 1,
                    32'h0000_1120, 32'h0040_0D14, 2, 1'b0, 5, 7'h45, 32'h2468_A001, 32'hABCD_E019);
        tbl[1] = mk(32'h0000_1000, 19'h12345, 32'h0040_0000, 32'hABCD_E019, 0, 0, 1, 1,
                    32'h0000_1120, 32'h0, 1, 1'b1, 3, 7'h45, 32'h0, 32'h0);
        tbl[2] = mk(32'h0000_1000, 19'h12345, 32'h0040_0001, 32'hABCD_E019, 3, 0, 1, 1,
                    32'h0000_1120, 32'h0040_0D14, 2, 1'b0, 8, 7'h45, 32'h2468_A001, 32'hABCD_E019);
        tbl[3] = mk(32'hFFFF_F7FF, 19'h7FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 2, 2, 3,
                    32'hFFFF_F7FC, 32'hFFFF_FFFC, 2, 1'b1, 10, 7'h7F, 32'h0, 32'h0);
        tbl[4] = mk(32'h0000_0800, 19'h00400, 32'h1234_5FFF, 32'h0000_0001, 1, 1, 3, 1,
                    32'h0000_0804, 32'h1234_5000, 2, 1'b0, 9, 7'h00, 32'h0080_0001, 32'h0000_0001);

        clr();
        bus.vpn = '0; bus.ptbr = '0; bus.mem_rdata = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset done", {31'b0, bus.done}, 32'd0);
        chk("reset fault", {31'b0, bus.fault}, 32'd0);
        chk("reset mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("reset we", {30'b0, bus.msr_imm_tlbl_we, bus.msr_imm_tlbh_we}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_walk(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            r.ptbr = $urandom; r.vpn = 19'($urandom); r.pde = $urandom; r.pte = $urandom;
            r.pde[0] = ($urandom_range(0, 3) != 0);
            r.pte[0] = ($urandom_range(0, 3) != 0);
            r.bp1 = $urandom_range(0, 3); r.bp2 = $urandom_range(0, 3);
            r.lat1 = $urandom_range(1, 3); r.lat2 = $urandom_range(1, 3);
            run_walk(model(r), $sformatf("rnd%0d", i));
        end

        // Abort in L2_WAIT, response two cycles later; start during DRAIN must be ignored
        d0 = ev_done; w0 = ev_we;
        step(); clr(); bus.start = 1'b1; bus.vpn = 19'h12345; bus.ptbr = 32'h1000;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0040_0001;
        step(); clr(); chk("abrt_wait l2_req", {31'b0, bus.mem_req}, 32'd1); bus.mem_ready = 1'b1;
        step(); clr(); bus.abort = 1'b1;
        step(); clr(); chk("abrt_wait drain busy", {31'b0, bus.busy}, 32'd1);
        chk("abrt_wait drain req", {31'b0, bus.mem_req}, 32'd0);
        bus.start = 1'b1; bus.vpn = 19'h00007;
        step(); clr(); chk("abrt_wait drain busy2", {31'b0, bus.busy}, 32'd1);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABCD_E019;
        step(); clr(); chk("abrt_wait idle", {31'b0, bus.busy}, 32'd0);
        step();
        chk("abrt_wait no done", 32'(ev_done - d0), 32'd0);
        chk("abrt_wait no we", 32'(ev_we - w0), 32'd0);
        run_walk(tbl[0], "after_abort");

        // Abort before accept in L1_REQ and in L2_REQ, then abort on accept, then abort with rvalid
        d0 = ev_done; w0 = ev_we;
        step(); clr(); bus.start = 1'b1; bus.vpn = 19'h12345; bus.ptbr = 32'h1000;
        step(); clr(); chk("abrt_l1 req", {31'b0, bus.mem_req}, 32'd1); bus.abort = 1'b1;
        step(); clr(); chk("abrt_l1 busy", {31'b0, bus.busy}, 32'd0);
        chk("abrt_l1 req_drop", {31'b0, bus.mem_req}, 32'd0);
        step(); clr(); bus.start = 1'b1;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0040_0001;
        step(); clr(); chk("abrt_l2 req", {31'b0, bus.mem_req}, 32'd1); bus.abort = 1'b1;
        step(); clr(); chk("abrt_l2 busy", {31'b0, bus.busy}, 32'd0);
        chk("abrt_l2 req_drop", {31'b0, bus.mem_req}, 32'd0);
        step(); clr(); bus.start = 1'b1;
        step(); clr(); bus.mem_ready = 1'b1; bus.abort = 1'b1;
        step(); clr(); chk("abrt_acc drain", {31'b0, bus.busy}, 32'd1);
        chk("abrt_acc req", {31'b0, bus.mem_req}, 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0040_0001;
        step(); clr(); chk("abrt_acc idle", {31'b0, bus.busy}, 32'd0);
        step(); clr(); bus.start = 1'b1;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); bus.mem_rvalid = 1'b1; bus.abort = 1'b1; bus.mem_rdata = 32'h0040_0001;
        step(); clr(); chk("abrt_rv idle", {31'b0, bus.busy}, 32'd0);
        chk("abrt_rv req", {31'b0, bus.mem_req}, 32'd0);
        step();
        chk("abrt_seq no done", 32'(ev_done - d0), 32'd0);
        chk("abrt_seq no we", 32'(ev_we - w0), 32'd0);

        // Abort during FILL does not suppress the write
        step(); clr(); bus.start = 1'b1; bus.vpn = 19'h12345; bus.ptbr = 32'h1000;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0040_0001;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABCD_E019;
        step(); clr(); chk("abrt_fill done", {31'b0, bus.done}, 32'd1);
        chk("abrt_fill we", {31'b0, bus.msr_imm_tlbh_we}, 32'd1);
        chk("abrt_fill tlbh", bus.msr_imm_tlbh_nxt, 32'hABCD_E019);
        bus.abort = 1'b1;
        step(); clr(); chk("abrt_fill idle", {31'b0, bus.busy}, 32'd0);
        chk("abrt_fill done_pulse", {31'b0, bus.done}, 32'd0);

        // Reset in L2_WAIT, then a late response lands in IDLE
        step(); clr(); bus.start = 1'b1; bus.vpn = 19'h12345; bus.ptbr = 32'h1000;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0040_0001;
        step(); clr(); bus.mem_ready = 1'b1;
        step(); clr(); rst = 1'b1;
        step(); clr(); rst = 1'b0;
        d0 = ev_done; w0 = ev_we;
        chk("rst_mid busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_mid req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mid addr", bus.mem_addr, 32'd0);
        chk("rst_mid done", {30'b0, bus.done, bus.fault}, 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABCD_E019;
        step(); clr();
        step();
        chk("rst_mid stray busy", {31'b0, bus.busy}, 32'd0);
        step();
        chk("rst_mid no done", 32'(ev_done - d0), 32'd0);
        chk("rst_mid no we", 32'(ev_we - w0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
